panda_dpram: RTL and testbench
==============================

Name: panda_dpram

Overview:
- Parametrised dual-port successor to panda_ram: two independent read/write ports (A, B) on a single clock.
- Per-port byte write enables, optional output register (1- or 2-cycle read latency), selectable read-during-write mode, deterministic same-address collision rules, per-port read-valid strobes.
- Used as shared instruction/data memory and as a debug-accessible scratchpad in the Panda core.

Parameters:
- DataWidth, 32, word width in bits; must be a multiple of 8.
- Depth, 64, number of words; need not be a power of 2.
- OutputReg, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- WriteFirst, 1, 1 means reads return newly written data on an address collision; 0 means reads return old data.
- InitFile, "", hex memory image loaded at elaboration; empty means contents are undefined.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- a_ce_i  in  1  port A access enable
- a_we_i  in  DataWidth/8  port A byte write enables; bit k covers data[8k+7:8k]
- a_addr_i  in  $clog2(Depth)  port A word address
- a_data_i  in  DataWidth  port A write data
- a_data_o  out  DataWidth  port A read data
- a_valid_o  out  1  port A read data valid, one pulse per access
- b_ce_i, b_we_i, b_addr_i, b_data_i, b_data_o, b_valid_o: same as port A, for port B

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge.
  - Reset is synchronous, active-low.
  - While rst_ni=0: a_data_o=b_data_o=0, a_valid_o=b_valid_o=0, all pipeline stages cleared, and writes are ignored.
  - Memory array contents are never cleared by reset.
- Access:
  - When x_ce_i=1 on edge N, the port performs an access.
  - Bytes with x_we_i[k]=1 are written at x_addr_i.
  - Every access, including a write or partial write, returns a read word.
- Latency:
  - OutputReg=0: x_data_o is updated and x_valid_o=1 after edge N, i.e. during cycle N+1.
  - OutputReg=1: the same happens one cycle later.
  - x_valid_o is high for exactly one cycle per access. Back-to-back accesses give continuous valid with one word per cycle.
- Idle: when x_ce_i=0, x_data_o holds its last value and x_valid_o=0.
- Own-port read-during-write:
  - WriteFirst=1: the returned word is the old word with the enabled bytes replaced by x_data_i.
  - WriteFirst=0: the returned word is the pre-write contents.
- Same-address collision (both ce=1, equal addresses):
  - Both ports writing: per byte, A wins where a_we_i[k]=1; B's byte is written where a_we_i[k]=0 and b_we_i[k]=1.
  - Read data for both ports: WriteFirst=1 returns the final merged word after both writes; WriteFirst=0 returns the pre-edge word.
- Out-of-range address (x_addr_i >= Depth, only possible when Depth is not a power of 2):
  - Writes are dropped; no aliasing.
  - Read returns 0; valid still pulses.
- Reset mid-operation: in-flight reads are discarded and no valid pulse is issued for them. The first access after rst_ni returns high behaves normally.
- Width rules: DataWidth % 8 != 0 or Depth < 2 is a fatal elaboration error.
- Implementation: memory inferable as block RAM.
  - Collision merging and WriteFirst bypass are done with explicit compare/mux logic on registered addresses.
  - No simulation-only constructs in RTL except $readmemh.

Test Plan:
1. Init/read: InitFile sets word i = 32'h1000_0000+i. Port A reads addresses 0..19 back-to-back with OutputReg=0 → a_data_o=32'h1000_0000+i one cycle after each access, with a_valid_o continuously high.
2. Byte enables: write 32'hABCDEF89 to addr 40 with we=4'b1111, 41 with 4'b0011, 42 with 4'b0001, 43 with 4'b0101 over init 0, then read back → 32'hABCDEF89, 32'h0000EF89, 32'h00000089, 32'h00CD0089.
3. Collision: addr 10 holds 32'h11111111. Same edge: A writes 32'hAAAAAAAA with we=4'b0011, B writes 32'hBBBBBBBB with we=4'b1110.
   - Memory becomes 32'hBBBBAAAA.
   - With WriteFirst=1, both ports return 32'hBBBBAAAA.
   - With WriteFirst=0, both ports return 32'h11111111.
4. Latency mode: OutputReg=1, A reads addr 5 → a_valid_o and the data appear exactly 2 cycles after the access edge, with no valid pulse in between.
5. Reset mid-flight: OutputReg=1, issue reads on both ports, then drive rst_ni=0 on the next edge → outputs are 0, no valid pulses; memory contents at 40..43 unchanged on read-back after reset.
6. Out-of-range: Depth=48, write to addr 50 then read addr 50 and addr 2 → addr 50 reads 0 with valid=1, and addr 2 is unchanged (no aliasing).

Source files
------------

// File: rtl/panda_dpram.sv
// Dual-port, single-clock RAM with byte enables and selectable read latency.
// Same-address collisions and the write-first bypass are resolved after the array read.
module panda_dpram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 64,
  parameter int unsigned OutputReg = 0,
  parameter int unsigned WriteFirst = 1,
  parameter string       InitFile  = "",
  localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned NumBytes  = (DataWidth >= 8) ? DataWidth / 8 : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_ce_i,
  input  logic [NumBytes-1:0]  a_we_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  output logic [DataWidth-1:0] a_data_o,
  output logic                 a_valid_o,
  input  logic                 b_ce_i,
  input  logic [NumBytes-1:0]  b_we_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic [DataWidth-1:0] b_data_o,
  output logic                 b_valid_o
);

  if ((DataWidth % 8) != 0 || Depth < 2) begin : g_bad_params
    $fatal(1, "panda_dpram: DataWidth must be a multiple of 8 and Depth >= 2");
  end

  logic [DataWidth-1:0] r_mem [Depth];

  // Handshake: an access is x_ce_i=1 at a rising edge; x_valid_o pulses for exactly one
  // cycle when its read word is on x_data_o. There is no back-pressure.

  logic w_a_inr;
  logic w_b_inr;
  assign w_a_inr = ({1'b0, a_addr_i} < (AddrWidth + 1)'(Depth));
  assign w_b_inr = ({1'b0, b_addr_i} < (AddrWidth + 1)'(Depth));

  // Array write: A is applied after B so A owns every byte both ports enable.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (b_ce_i && w_b_inr && b_we_i[k]) r_mem[b_addr_i][8*k +: 8] <= b_data_i[8*k +: 8];
        if (a_ce_i && w_a_inr && a_we_i[k]) r_mem[a_addr_i][8*k +: 8] <= a_data_i[8*k +: 8];
      end
    end
  end

  // First stage: pre-edge array word plus the access context needed for the bypass.
  logic                 r_a_act, r_b_act;
  logic                 r_a_inr, r_b_inr;
  logic [AddrWidth-1:0] r_a_addr, r_b_addr;
  logic [NumBytes-1:0]  r_a_we, r_b_we;
  logic [DataWidth-1:0] r_a_wd, r_b_wd;
  logic [DataWidth-1:0] r_a_old, r_b_old;
  logic [DataWidth-1:0] r_a_q, r_b_q;

  logic                 w_col;
  logic [DataWidth-1:0] w_a_word, w_b_word;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a_act  <= 1'b0;
      r_b_act  <= 1'b0;
      r_a_inr  <= 1'b0;
      r_b_inr  <= 1'b0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_a_we   <= '0;
      r_b_we   <= '0;
      r_a_wd   <= '0;
      r_b_wd   <= '0;
      r_a_old  <= '0;
      r_b_old  <= '0;
      r_a_q    <= '0;
      r_b_q    <= '0;
    end else begin
      r_a_act <= a_ce_i;
      r_b_act <= b_ce_i;
      if (a_ce_i) begin
        r_a_inr  <= w_a_inr;
        r_a_addr <= a_addr_i;
        r_a_we   <= a_we_i;
        r_a_wd   <= a_data_i;
        r_a_old  <= w_a_inr ? r_mem[a_addr_i] : '0;
      end
      if (b_ce_i) begin
        r_b_inr  <= w_b_inr;
        r_b_addr <= b_addr_i;
        r_b_we   <= b_we_i;
        r_b_wd   <= b_data_i;
        r_b_old  <= w_b_inr ? r_mem[b_addr_i] : '0;
      end
      if (r_a_act) r_a_q <= w_a_word;
      if (r_b_act) r_b_q <= w_b_word;
    end
  end

  // Rebuild the post-write word from the old word and both ports' registered writes.
  always_comb begin
    w_col    = r_a_act && r_b_act && r_a_inr && (r_a_addr == r_b_addr);
    w_a_word = r_a_old;
    w_b_word = r_b_old;
    if (WriteFirst != 0) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (r_a_inr && r_a_we[k]) begin
          w_a_word[8*k +: 8] = r_a_wd[8*k +: 8];
        end else if (w_col && r_b_we[k]) begin
          w_a_word[8*k +: 8] = r_b_wd[8*k +: 8];
        end
        if (w_col && r_a_we[k]) begin
          w_b_word[8*k +: 8] = r_a_wd[8*k +: 8];
        end else if (r_b_inr && r_b_we[k]) begin
          w_b_word[8*k +: 8] = r_b_wd[8*k +: 8];
        end
      end
    end
  end

  if (OutputReg != 0) begin : g_oreg
    logic r_a_qv, r_b_qv;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_a_qv <= 1'b0;
        r_b_qv <= 1'b0;
      end else begin
        r_a_qv <= r_a_act;
        r_b_qv <= r_b_act;
      end
    end
    assign a_data_o  = r_a_q;
    assign b_data_o  = r_b_q;
    assign a_valid_o = r_a_qv;
    assign b_valid_o = r_b_qv;
  end else begin : g_noreg
    // r_x_q keeps the last returned word so the output holds while the port idles.
    assign a_data_o  = r_a_act ? w_a_word : r_a_q;
    assign b_data_o  = r_b_act ? w_b_word : r_b_q;
    assign a_valid_o = r_a_act;
    assign b_valid_o = r_b_act;
  end

endmodule

// File: tb/tb_panda_dpram.sv
// Directed bench for panda_dpram: four instances share one stimulus bus and differ
// in WriteFirst, OutputReg and Depth.
module tb_panda_dpram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_ce, b_ce;
  logic [3:0]  a_we, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_di, b_di;

  // Index 0: default, 1: WriteFirst=0, 2: OutputReg=1, 3: Depth=48
  logic [31:0] a_do [4];
  logic [31:0] b_do [4];
  logic        a_v  [4];
  logic        b_v  [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  panda_dpram u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_ce_i(a_ce), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_di), .a_data_o(a_do[0]), .a_valid_o(a_v[0]),
    .b_ce_i(b_ce), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_di), .b_data_o(b_do[0]), .b_valid_o(b_v[0])
  );

  panda_dpram #(.WriteFirst(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_ce_i(a_ce), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_di), .a_data_o(a_do[1]), .a_valid_o(a_v[1]),
    .b_ce_i(b_ce), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_di), .b_data_o(b_do[1]), .b_valid_o(b_v[1])
  );

  panda_dpram #(.OutputReg(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_ce_i(a_ce), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_di), .a_data_o(a_do[2]), .a_valid_o(a_v[2]),
    .b_ce_i(b_ce), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_di), .b_data_o(b_do[2]), .b_valid_o(b_v[2])
  );

  panda_dpram #(.Depth(48)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_ce_i(a_ce), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_di), .a_data_o(a_do[3]), .a_valid_o(a_v[3]),
    .b_ce_i(b_ce), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_di), .b_data_o(b_do[3]), .b_valid_o(b_v[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ce, input logic [3:0] we, input logic [5:0] addr, input logic [31:0] data);
    a_ce = ce; a_we = we; a_addr = addr; a_di = data;
  endtask

  task automatic drive_b(input logic ce, input logic [3:0] we, input logic [5:0] addr, input logic [31:0] data);
    b_ce = ce; b_we = we; b_addr = addr; b_di = data;
  endtask

  task automatic idle();
    drive_a(1'b0, 4'h0, 6'd0, 32'h0);
    drive_b(1'b0, 4'h0, 6'd0, 32'h0);
  endtask

  logic [3:0]  be_we  [4] = '{4'b1111, 4'b0011, 4'b0001, 4'b0101};
  logic [31:0] be_exp [4] = '{32'hABCDEF89, 32'h0000EF89, 32'h00000089, 32'h00CD0089};

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    check_eq("rst_a_data", a_do[0], 32'h0);
    check_eq("rst_a_valid", {31'h0, a_v[0]}, 32'h0);
    check_eq("rst_b_valid", {31'h0, b_v[0]}, 32'h0);
    check_eq("rst_oreg_a_data", a_do[2], 32'h0);
    rst_n = 1'b1;
    step();

    // Preload: words 0..19 = 0x1000_0000+i, words 40..43 = 0
    for (int i = 0; i < 20; i++) begin
      drive_b(1'b1, 4'hF, 6'(i), 32'h1000_0000 + 32'(i));
      step();
    end
    for (int i = 40; i < 44; i++) begin
      drive_b(1'b1, 4'hF, 6'(i), 32'h0);
      step();
    end
    idle();
    step();
    step();

    // Back-to-back reads on port A, one-cycle latency
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b1, 4'h0, 6'(i), 32'h0);
      step();
      check_eq($sformatf("burst_data[%0d]", i), a_do[0], 32'h1000_0000 + 32'(i));
      check_eq($sformatf("burst_valid[%0d]", i), {31'h0, a_v[0]}, 32'h1);
    end
    idle();
    step();
    check_eq("idle_valid", {31'h0, a_v[0]}, 32'h0);
    check_eq("idle_hold", a_do[0], 32'h1000_0013);

    // Byte enables; write-first returns the merged word, read-first the old word
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, be_we[i], 6'(40 + i), 32'hABCDEF89);
      step();
      check_eq($sformatf("be_wf_ret[%0d]", i), a_do[0], be_exp[i]);
      check_eq($sformatf("be_rf_ret[%0d]", i), a_do[1], 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'h0, 6'(40 + i), 32'h0);
      step();
      check_eq($sformatf("be_read[%0d]", i), a_do[0], be_exp[i]);
    end
    idle();
    step();

    // Same-address collision at word 10
    drive_b(1'b1, 4'hF, 6'd10, 32'h1111_1111);
    step();
    drive_a(1'b1, 4'b0011, 6'd10, 32'hAAAA_AAAA);
    drive_b(1'b1, 4'b1110, 6'd10, 32'hBBBB_BBBB);
    step();
    check_eq("col_wf_a", a_do[0], 32'hBBBB_AAAA);
    check_eq("col_wf_b", b_do[0], 32'hBBBB_AAAA);
    check_eq("col_rf_a", a_do[1], 32'h1111_1111);
    check_eq("col_rf_b", b_do[1], 32'h1111_1111);
    check_eq("col_valid_b", {31'h0, b_v[0]}, 32'h1);
    drive_a(1'b1, 4'h0, 6'd10, 32'h0);
    drive_b(1'b0, 4'h0, 6'd0, 32'h0);
    step();
    check_eq("col_mem_wf", a_do[0], 32'hBBBB_AAAA);
    check_eq("col_mem_rf", a_do[1], 32'hBBBB_AAAA);
    idle();
    step();
    step();

    // Two-cycle latency on the registered-output instance
    drive_a(1'b1, 4'h0, 6'd5, 32'h0);
    step();
    check_eq("oreg_valid_n1", {31'h0, a_v[2]}, 32'h0);
    idle();
    step();
    check_eq("oreg_valid_n2", {31'h0, a_v[2]}, 32'h1);
    check_eq("oreg_data_n2", a_do[2], 32'h1000_0005);
    step();
    check_eq("oreg_valid_n3", {31'h0, a_v[2]}, 32'h0);

    // Reset while reads are in flight
    drive_a(1'b1, 4'h0, 6'd0, 32'h0);
    drive_b(1'b1, 4'h0, 6'd1, 32'h0);
    step();
    idle();
    rst_n = 1'b0;
    step();
    check_eq("rstmid_a_data", a_do[2], 32'h0);
    check_eq("rstmid_b_data", b_do[2], 32'h0);
    check_eq("rstmid_a_valid", {31'h0, a_v[2]}, 32'h0);
    check_eq("rstmid_b_valid", {31'h0, b_v[2]}, 32'h0);
    step();
    check_eq("rstmid_a_valid2", {31'h0, a_v[2]}, 32'h0);
    check_eq("rstmid_b_valid2", {31'h0, b_v[2]}, 32'h0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'h0, 6'(40 + i), 32'h0);
      step();
      idle();
      step();
      check_eq($sformatf("post_rst_hold[%0d]", i), a_do[0], be_exp[i]);
      check_eq($sformatf("post_rst_oreg[%0d]", i), a_do[2], be_exp[i]);
      check_eq($sformatf("post_rst_oreg_v[%0d]", i), {31'h0, a_v[2]}, 32'h1);
    end

    // Out-of-range address on the Depth=48 instance
    drive_a(1'b1, 4'hF, 6'd50, 32'hDEAD_BEEF);
    step();
    check_eq("oor_wr_ret", a_do[3], 32'h0);
    check_eq("oor_wr_valid", {31'h0, a_v[3]}, 32'h1);
    drive_a(1'b1, 4'h0, 6'd50, 32'h0);
    step();
    check_eq("oor_rd_data", a_do[3], 32'h0);
    check_eq("oor_rd_valid", {31'h0, a_v[3]}, 32'h1);
    drive_a(1'b1, 4'h0, 6'd2, 32'h0);
    step();
    check_eq("oor_no_alias", a_do[3], 32'h1000_0002);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
